// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the memory-port arbiter.
package mem_arb_pkg;

  localparam int MEM_ARB_MAX_CH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational picker: first asserted request found scanning upward from
// start_idx with wrap-around; start_idx = 0 gives plain lowest-index priority.
module rr_picker #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  start_idx,
  output logic [NUM_CH-1:0] grant_onehot,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    for (int off = 0; off < NUM_CH; off++) begin
      int cand;
      cand = int'(start_idx) + off;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!grant_valid && req[cand]) begin
        grant_valid        = 1'b1;
        grant_idx          = cand[IDX_W-1:0];
        grant_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Multi-channel single-port memory arbiter (IDLE -> ACCESS -> DONE).
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise lowest index wins.
//
// state  | meaning
// IDLE   | no transaction; pick a requester when any is pending
// ACCESS | memory command held until mem_ack
// DONE   | one-cycle ch_ack to the granted channel, then back to IDLE
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_read_req,
  input  logic [NUM_CH-1:0]          ch_write_req,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_write_data,
  output logic [NUM_CH-1:0]          ch_ack,
  output logic [DATA_W-1:0]          ch_read_data,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic                       mem_ack,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data_write,
  input  logic [DATA_W-1:0]          mem_data_read,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_CH);

  arb_state_e state_q, state_d;

  logic [NUM_CH-1:0] req_any;
  logic [NUM_CH-1:0] pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [IDX_W-1:0]  start_idx;

  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [NUM_CH-1:0] ack_q, ack_d;

  assign req_any = ch_read_req | ch_write_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search resumes just past the last granted channel.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && pick_valid) begin
      if (pick_idx == IDX_W'(NUM_CH - 1)) ptr_d = '0;
      else                                ptr_d = pick_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign start_idx = ptr_q;
`else
  assign start_idx = '0;
`endif

  rr_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_picker (
    .req          (req_any),
    .start_idx    (start_idx),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .grant_valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (mem_ack)    state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    if (state_q == ST_IDLE && pick_valid) begin
      grant_d = pick_idx;
      // A channel asking for both is served as a write; its read stays pending.
      write_d = |(ch_write_req & pick_onehot);
      addr_d  = ch_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
      wdata_d = ch_write_data[int'(pick_idx)*DATA_W +: DATA_W];
    end
    if (state_q == ST_ACCESS && mem_ack) begin
      rdata_d         = mem_data_read;
      ack_d[grant_q]  = 1'b1;
    end
    mem_read_d  = (state_d == ST_ACCESS) && !write_d;
    mem_write_d = (state_d == ST_ACCESS) &&  write_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ack_q       <= '0;
    end else begin
      grant_q     <= grant_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      ack_q       <= ack_d;
    end
  end

  assign ch_ack         = ack_q;
  assign ch_read_data   = rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_addr       = addr_q;
  assign mem_data_write = wdata_q;
  assign grant_id       = grant_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr (4 channels): directed scenarios plus randomized
// traffic checked against a transaction-level arbitration model.
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              reset;
  logic [N-1:0]      ch_read_req, ch_write_req;
  logic [N*AW-1:0]   ch_addr;
  logic [N*DW-1:0]   ch_write_data;
  logic [N-1:0]      ch_ack;
  logic [DW-1:0]     ch_read_data;
  logic              mem_read, mem_write, mem_ack;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data_write, mem_data_read;
  logic [1:0]        grant_id;
  logic              busy;

  mem_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .ch_read_req(ch_read_req), .ch_write_req(ch_write_req),
    .ch_addr(ch_addr), .ch_write_data(ch_write_data),
    .ch_ack(ch_ack), .ch_read_data(ch_read_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_data_write(mem_data_write),
    .mem_data_read(mem_data_read),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Requester-side model: what each channel is currently asking for.
  logic [N-1:0]  rd_m, wr_m;
  logic [AW-1:0] addr_m [N];
  logic [DW-1:0] wd_m   [N];
  int            ptr_m;
  logic [DW-1:0] last_rd;
  bit            last_was_read;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      ch_read_req[c]            = rd_m[c];
      ch_write_req[c]           = wr_m[c];
      ch_addr[c*AW +: AW]       = addr_m[c];
      ch_write_data[c*DW +: DW] = wd_m[c];
    end
  endtask

  function automatic int pick(input logic [N-1:0] pend, input int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (pend[c]) return c;
    end
    return 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; mem_ack = 1'b0; mem_data_read = '0;
    rd_m = '0; wr_m = '0;
    drive();
    step();
    step();
    reset = 1'b0;
    ptr_m = 0;
    last_was_read = 1'b0;
  endtask

  // One full transaction from an IDLE cycle with at least one request pending.
  task automatic do_txn(input int lat, input bit hold_ack, input bit scramble,
                        input logic [DW-1:0] rdv, output int gid_seen);
    int win;
    bit ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    win = pick(rd_m | wr_m, ptr_m);
    ew  = wr_m[win];
    ea  = addr_m[win];
    ed  = wd_m[win];
    step();
    gid_seen = int'(grant_id);
    check("grant_id", grant_id, win);
    check("cmd_read", mem_read, !ew);
    check("cmd_write", mem_write, ew);
    check("mem_addr", mem_addr, ea);
    if (ew) check("mem_wdata", mem_data_write, ed);
    check("busy_access", busy, 1);
    check("no_early_ack", ch_ack, 0);
    if (scramble) begin
      int o;
      addr_m[win] = $urandom;
      wd_m[win]   = $urandom;
      o = (win + 1 + $urandom_range(0, N - 2)) % N;
      if (!rd_m[o] && !wr_m[o]) begin
        rd_m[o] = 1'b1; addr_m[o] = $urandom;
      end
      drive();
    end
    for (int i = 0; i < lat; i++) begin
      step();
      check("hold_read", mem_read, !ew);
      check("hold_write", mem_write, ew);
      check("hold_addr", mem_addr, ea);
      check("hold_ack0", ch_ack, 0);
    end
    mem_data_read = rdv;
    mem_ack = 1'b1;
    step();
    check("ch_ack", ch_ack, 1 << win);
    check("done_read_low", mem_read, 0);
    check("done_write_low", mem_write, 0);
    check("busy_done", busy, 1);
    if (!ew) check("rdata", ch_read_data, rdv);
    mem_ack = hold_ack;
    if (ew) wr_m[win] = 1'b0; else rd_m[win] = 1'b0;
    drive();
    last_was_read = !ew;
    if (!ew) last_rd = rdv;
    mem_data_read = $urandom;
    step();
    check("idle_ack0", ch_ack, 0);
    check("idle_busy", busy, 0);
    check("idle_cmd", {mem_read, mem_write}, 0);
    if (last_was_read) check("rdata_hold", ch_read_data, last_rd);
    mem_ack = 1'b0;
    ptr_m = RR ? (win + 1) % N : 0;
  endtask

  initial begin
    int g;
    int exp_seq [5];
    reset = 1'b1; mem_ack = 1'b0; mem_data_read = '0;
    rd_m = '0; wr_m = '0;
    for (int c = 0; c < N; c++) begin addr_m[c] = '0; wd_m[c] = '0; end
    drive();
    step();
    check("rst_state", {busy, mem_read, mem_write}, 0);
    check("rst_ack", ch_ack, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_data_write, 0);
    check("rst_rdata", ch_read_data, 0);
    check("rst_gid", grant_id, 0);
    do_reset();

    // Single read on ch1, ack in cycle 3.
    rd_m[1] = 1'b1; addr_m[1] = 32'h100;
    drive();
    do_txn(2, 1'b0, 1'b0, 32'hDEADBEEF, g);

    // All channels requesting with one-cycle memory latency.
    do_reset();
    for (int i = 0; i < 5; i++) exp_seq[i] = RR ? (i % N) : 0;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < N; c++) begin
        rd_m[c] = 1'b1; addr_m[c] = 32'h1000 + c * 4;
      end
      drive();
      do_txn(0, 1'b0, 1'b0, $urandom, g);
      check("rr_seq", g, exp_seq[i]);
    end

    // Read+write on ch0: write first, read left pending.
    do_reset();
    rd_m[0] = 1'b1; wr_m[0] = 1'b1; addr_m[0] = 32'h40; wd_m[0] = 32'h12345678;
    drive();
    do_txn(1, 1'b0, 1'b0, $urandom, g);
    do_txn(0, 1'b0, 1'b0, 32'h0BADF00D, g);

    // Reset in the second ACCESS cycle aborts the transaction.
    do_reset();
    rd_m[2] = 1'b1; addr_m[2] = 32'h200;
    drive();
    step();
    check("abort_gid_pre", grant_id, 2);
    step();
    check("abort_read_pre", mem_read, 1);
    reset = 1'b1; rd_m = '0; drive();
    step();
    check("abort_read", mem_read, 0);
    check("abort_ack", ch_ack, 0);
    check("abort_gid", grant_id, 0);
    check("abort_busy", busy, 0);
    reset = 1'b0; ptr_m = 0; last_was_read = 1'b0;
    step();
    check("abort_no_ack", ch_ack, 0);

    // Stray mem_ack while idle.
    mem_ack = 1'b1;
    step();
    check("stray_ack", ch_ack, 0);
    check("stray_busy", busy, 0);
    mem_ack = 1'b0;
    step();
    check("stray_ack2", ch_ack, 0);
    check("stray_busy2", busy, 0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      for (int c = 0; c < N; c++) begin
        if (!rd_m[c] && !wr_m[c] && $urandom_range(0, 1) == 1) begin
          int code;
          code = $urandom_range(1, 3);
          rd_m[c] = code[0]; wr_m[c] = code[1];
          addr_m[c] = $urandom; wd_m[c] = $urandom;
        end
      end
      if ((rd_m | wr_m) == '0) begin
        int c;
        c = $urandom_range(0, N - 1);
        rd_m[c] = 1'b1; addr_m[c] = $urandom;
      end
      drive();
      do_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameter NUM_CH, default 2, number of requester channels (2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ch_read_req  input  NUM_CH  per-channel read request, held until ack.
REQ-007 ch_write_req  input  NUM_CH  per-channel write request, held until ack.
REQ-008 ch_addr  input  NUM_CH*ADDR_W  packed per-channel address; channel i at [i*ADDR_W +: ADDR_W].
REQ-009 ch_write_data  input  NUM_CH*DATA_W  packed per-channel write data.
REQ-010 ch_ack  output  NUM_CH  one-cycle completion pulse, one-hot or zero.
REQ-011 ch_read_data  output  DATA_W  read data, broadcast to all channels, valid in the ch_ack cycle.
REQ-012 mem_read, mem_write  output  1 each  memory-port commands, registered.
REQ-013 mem_ack  input  1  memory completion.
REQ-014 mem_addr  output  ADDR_W;  mem_data_write  output  DATA_W;  mem_data_read  input  DATA_W.
REQ-015 grant_id  output  $clog2(NUM_CH)  index of the channel owning the port; busy  output  1  state != IDLE.

Function
REQ-016 FSM states IDLE, ACCESS, DONE.
REQ-017 IDLE: with any request pending, select one channel, latch its addr/data/op, enter ACCESS next edge; with none, stay.
REQ-018 ACCESS: mem_read or mem_write (never both) held high with stable mem_addr/mem_data_write until mem_ack sampled high.
REQ-019 mem_ack in ACCESS: latch mem_data_read into ch_read_data, enter DONE; ch_ack[grant_id]=1 for exactly that DONE cycle; mem_read/mem_write low in DONE.
REQ-020 DONE always returns to IDLE after one cycle, so a requester dropping req on the edge after ack is never re-granted.
REQ-021 Latency: req seen in IDLE at cycle 0 -> mem command high at cycle 1; mem_ack at cycle k -> ch_ack at cycle k+1.
REQ-022 Channel with both read and write requests: write serviced; read remains pending.
REQ-023 mem_ack in IDLE or DONE is ignored.
REQ-024 Requests changing during ACCESS/DONE do not affect the latched transaction.
REQ-025 ch_read_data holds its last value outside DONE; after a write it is unspecified.

Reset
REQ-026 Reset: state IDLE, mem_read=0, mem_write=0, ch_ack=0, mem_addr=0, mem_data_write=0, ch_read_data=0, grant_id=0, busy=0, RR pointer=0.
REQ-027 Reset during ACCESS aborts: no ch_ack issued, mem command low next cycle.

Configuration
REQ-028 Macro MEM_ARB_ROUND_ROBIN_EN defined: round-robin; after granting channel g, search starts at (g+1) mod NUM_CH; pointer advances only on grant.
REQ-029 Macro undefined: fixed priority, lowest index wins; no pointer register.

Structure
REQ-030 Package mem_arb_pkg: FSM state enum, MEM_ARB_MAX_CH=8 constant.
REQ-031 Sub-module rr_picker: combinational, request vector + start index in, one-hot grant + index out; used in both modes (start index tied 0 without macro).

Verification
REQ-032 Single read ch1, addr 0x100, mem_ack after 3 cycles, data 0xDEADBEEF -> mem_read cycles 1-3, ch_ack=2'b10 cycle 4, ch_read_data=0xDEADBEEF.
REQ-033 NUM_CH=4, all channels request continuously, mem_ack 1 cycle -> RR grants 0,1,2,3,0; fixed mode grants 0 repeatedly.
REQ-034 Ch0 read+write simultaneously, addr 0x40, wdata 0x12345678 -> mem_write with 0x12345678 first, then mem_read.
REQ-035 Reset asserted in ACCESS cycle 2 -> no ch_ack, mem_read low next cycle, grant_id=0.
REQ-036 mem_ack pulsed in IDLE with no requests -> no ch_ack, state remains IDLE.
REQ-037 Requester drops req the edge after ch_ack -> exactly one transaction per request, no duplicate grant.
